cache_cmd_issue: RTL and testbench

//  Front-end stage feeding the cache controller. Accepts raw trace records (numeric code + address),

---
 rtl/cache_cmd_issue_pkg.sv | 44 ++++
 rtl/cache_cmd_issue_cmd_fifo.sv | 54 +++++
 rtl/cache_cmd_issue.sv | 107 ++++++++++
 tb/tb_cache_cmd_issue.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_cmd_issue_pkg.sv
// cache_cmd_issue_pkg
//   Shared types for the cache command front-end: the cache instruction
//   encoding, raw trace codes and the trace-code decoder.
//   No ports (package).
package cache_cmd_issue_pkg;

    typedef enum logic [1:0] {
        READ       = 2'd0,
        WRITE      = 2'd1,
        INVALIDATE = 2'd2,
        RESET      = 2'd3
    } inst_t;

    typedef enum logic [3:0] {
        TR_READ  = 4'd0,
        TR_WRITE = 4'd1,
        TR_FETCH = 4'd2,
        TR_INVAL = 4'd3,
        TR_RESET = 4'd8,
        TR_STATS = 4'd9
    } trace_code_t;

    typedef struct packed {
        logic  push;
        inst_t inst;
    } decode_t;

    // Codes that are not cache commands (stats request, undefined codes)
    // return push=0; inst is then don't-care.
    function automatic decode_t decode_trace(input logic [3:0] code);
        decode_t d;
        d.push = 1'b1;
        d.inst = READ;
        case (code)
            TR_READ, TR_FETCH: d.inst = READ;
            TR_WRITE:          d.inst = WRITE;
            TR_INVAL:          d.inst = INVALIDATE;
            TR_RESET:          d.inst = RESET;
            default:           d.push = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/cache_cmd_issue_cmd_fifo.sv
// cmd_fifo
//   Generic in-order FIFO, DEPTH entries of W bits. Pointers carry one extra
//   wrap bit so full and empty are distinguishable without a separate count.
// Ports
//   clk, reset_n        clock, async active-low reset
//   push, wr_data       write request (ignored when full)
//   pop, rd_data        read request (ignored when empty), head entry
//   full, empty, count  status; count = entries held
module cmd_fifo #(
    parameter int W     = 34,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic [W-1:0]             wr_data,
    input  logic                     pop,
    output logic [W-1:0]             rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (wr_ptr[PW-1] != rd_ptr[PW-1]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty   = (wr_ptr == rd_ptr);
    assign count   = wr_ptr - rd_ptr;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
        end
    end

    // Storage needs no reset: contents are only observed between the pointers.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/cache_cmd_issue.sv
// cache_cmd_issue
//   Decodes trace records into cache instructions, queues them in order and
//   issues them to the cache over valid/ready. Stats-request and undefined
//   codes are consumed here and reported as one-cycle pulses.
//   Optional feature macro: CACHE_CMD_STATS_EN builds saturating issued-command
//   counters; without it the counter ports are tied to 0.
// Ports
//   clk, reset_n                      clock, async active-low reset
//   in_valid/in_ready/in_code/in_addr trace record input handshake
//   cmd_valid/cmd_ready/cmd_inst/cmd_addr  command output handshake (FIFO head)
//   occupancy                         entries held
//   stats_req, illegal                pulses for consumed non-cache codes
//   rd_cnt/wr_cnt/inv_cnt/rst_cnt     issued-command counters
module cache_cmd_issue
    import cache_cmd_issue_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 8,
    parameter int CNT_W  = 32
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [3:0]             in_code,
    input  logic [ADDR_W-1:0]      in_addr,
    output logic                   cmd_valid,
    input  logic                   cmd_ready,
    output inst_t                  cmd_inst,
    output logic [ADDR_W-1:0]      cmd_addr,
    output logic [$clog2(DEPTH):0] occupancy,
    output logic                   stats_req,
    output logic                   illegal,
    output logic [CNT_W-1:0]       rd_cnt,
    output logic [CNT_W-1:0]       wr_cnt,
    output logic [CNT_W-1:0]       inv_cnt,
    output logic [CNT_W-1:0]       rst_cnt
);
    localparam int W = ADDR_W + 2;

    decode_t           dec;
    logic              accept;
    logic              push;
    logic              pop;
    logic              full;
    logic              empty;
    logic [ADDR_W-1:0] push_addr;
    logic [W-1:0]      rd_data;

    assign dec       = decode_trace(in_code);
    assign in_ready  = !full;
    assign accept    = in_valid && in_ready;
    assign push      = accept && dec.push;
    assign push_addr = (dec.inst == RESET) ? '0 : in_addr;

    cmd_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push),
        .wr_data ({dec.inst, push_addr}),
        .pop     (pop),
        .rd_data (rd_data),
        .full    (full),
        .empty   (empty),
        .count   (occupancy)
    );

    // Head is masked while empty so the idle output is RESET/0, matching reset.
    assign cmd_valid = !empty;
    assign cmd_inst  = empty ? RESET : inst_t'(rd_data[W-1:ADDR_W]);
    assign cmd_addr  = empty ? '0 : rd_data[ADDR_W-1:0];
    assign pop       = cmd_valid && cmd_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stats_req <= 1'b0;
            illegal   <= 1'b0;
        end else begin
            stats_req <= accept && (in_code == TR_STATS);
            illegal   <= accept && !dec.push && (in_code != TR_STATS);
        end
    end

`ifdef CACHE_CMD_STATS_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_cnt  <= '0;
            wr_cnt  <= '0;
            inv_cnt <= '0;
            rst_cnt <= '0;
        end else if (pop) begin
            case (cmd_inst)
                READ:       if (rd_cnt  != '1) rd_cnt  <= rd_cnt  + CNT_W'(1);
                WRITE:      if (wr_cnt  != '1) wr_cnt  <= wr_cnt  + CNT_W'(1);
                INVALIDATE: if (inv_cnt != '1) inv_cnt <= inv_cnt + CNT_W'(1);
                default:    if (rst_cnt != '1) rst_cnt <= rst_cnt + CNT_W'(1);
            endcase
        end
    end
`else
    assign rd_cnt  = '0;
    assign wr_cnt  = '0;
    assign inv_cnt = '0;
    assign rst_cnt = '0;
`endif

endmodule

// File: tb/tb_cache_cmd_issue.sv
// tb_cache_cmd_issue
//   Scoreboard bench for cache_cmd_issue: accepted records are translated by
//   a queue-based reference model into expected commands; a monitor compares
//   every issued command, status output and counter against the model.
module tb_cache_cmd_issue;
    import cache_cmd_issue_pkg::*;

    localparam int ADDR_W = 32;
    localparam int DEPTH  = 8;
    localparam int CNT_W  = 4;
    localparam int OW     = $clog2(DEPTH) + 1;
    localparam int CMAX   = (1 << CNT_W) - 1;
`ifdef CACHE_CMD_STATS_EN
    localparam bit STATS_EN = 1'b1;
`else
    localparam bit STATS_EN = 1'b0;
`endif

    logic              clk;
    logic              reset_n;
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        in_code;
    logic [ADDR_W-1:0] in_addr;
    logic              cmd_valid;
    logic              cmd_ready;
    inst_t             cmd_inst;
    logic [ADDR_W-1:0] cmd_addr;
    logic [OW-1:0]     occupancy;
    logic              stats_req;
    logic              illegal;
    logic [CNT_W-1:0]  rd_cnt, wr_cnt, inv_cnt, rst_cnt;

    logic rand_rdy, rdy_fixed, rnd_bit;
    assign cmd_ready = rand_rdy ? rnd_bit : rdy_fixed;

    cache_cmd_issue #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_code   (in_code),
        .in_addr   (in_addr),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_inst  (cmd_inst),
        .cmd_addr  (cmd_addr),
        .occupancy (occupancy),
        .stats_req (stats_req),
        .illegal   (illegal),
        .rd_cnt    (rd_cnt),
        .wr_cnt    (wr_cnt),
        .inv_cnt   (inv_cnt),
        .rst_cnt   (rst_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1 rnd_bit = 1'($urandom_range(0, 1));
    end

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        inst_t             inst;
        logic [ADDR_W-1:0] addr;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   m_rd, m_wr, m_inv, m_rst;
    bit   exp_stats, exp_ill;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int sat(input int v);
        return (v >= CMAX) ? CMAX : v + 1;
    endfunction

    // Monitor / scoreboard: compare first, then apply this cycle's handshakes
    // to the model (they take effect at the coming rising edge).
    always @(negedge clk) begin
        if (!reset_n) begin
            exp_q.delete();
            m_rd = 0; m_wr = 0; m_inv = 0; m_rst = 0;
            exp_stats = 1'b0;
            exp_ill   = 1'b0;
            check("rst_cmd_valid", 64'(cmd_valid), 64'd0);
            check("rst_occupancy", 64'(occupancy), 64'd0);
            check("rst_in_ready", 64'(in_ready), 64'd1);
            check("rst_cmd_inst", 64'(cmd_inst), 64'(RESET));
            check("rst_cmd_addr", 64'(cmd_addr), 64'd0);
            check("rst_pulses", 64'({stats_req, illegal}), 64'd0);
            check("rst_counters", 64'({rd_cnt, wr_cnt, inv_cnt, rst_cnt}), 64'd0);
        end else begin
            check("occupancy", 64'(occupancy), 64'(exp_q.size()));
            check("cmd_valid", 64'(cmd_valid), 64'(exp_q.size() > 0));
            check("in_ready", 64'(in_ready), 64'(exp_q.size() < DEPTH));
            check("stats_req", 64'(stats_req), 64'(exp_stats));
            check("illegal", 64'(illegal), 64'(exp_ill));
            check("rd_cnt", 64'(rd_cnt), STATS_EN ? 64'(m_rd) : 64'd0);
            check("wr_cnt", 64'(wr_cnt), STATS_EN ? 64'(m_wr) : 64'd0);
            check("inv_cnt", 64'(inv_cnt), STATS_EN ? 64'(m_inv) : 64'd0);
            check("rst_cnt", 64'(rst_cnt), STATS_EN ? 64'(m_rst) : 64'd0);

            if (cmd_valid && cmd_ready && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("cmd_inst", 64'(cmd_inst), 64'(e.inst));
                check("cmd_addr", 64'(cmd_addr), 64'(e.addr));
                case (e.inst)
                    READ:       m_rd  = sat(m_rd);
                    WRITE:      m_wr  = sat(m_wr);
                    INVALIDATE: m_inv = sat(m_inv);
                    default:    m_rst = sat(m_rst);
                endcase
            end

            exp_stats = 1'b0;
            exp_ill   = 1'b0;
            if (in_valid && in_ready) begin
                case (int'(in_code))
                    0, 2:    exp_q.push_back('{READ, in_addr});
                    1:       exp_q.push_back('{WRITE, in_addr});
                    3:       exp_q.push_back('{INVALIDATE, in_addr});
                    8:       exp_q.push_back('{RESET, '0});
                    9:       exp_stats = 1'b1;
                    default: exp_ill = 1'b1;
                endcase
            end
        end
    end

    // Present one record and hold it until accepted. Called at posedge+2.
    task automatic send(input logic [3:0] code, input logic [ADDR_W-1:0] addr);
        int n;
        bit ok;
        in_valid = 1'b1;
        in_code  = code;
        in_addr  = addr;
        ok = 1'b0;
        n  = 0;
        while (!ok && n < 200) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #2;
            n++;
        end
        if (!ok) begin
            miscompares++;
            $display("FAIL send_timeout: code %0d not accepted after %0d cycles", code, n);
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        rand_rdy  = 1'b0;
        rdy_fixed = 1'b1;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk);
            #2;
            n++;
        end
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain_timeout: %0d commands still expected", exp_q.size());
        end
        repeat (2) @(posedge clk);
        #2;
    endtask

    initial begin
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_code   = '0;
        in_addr   = '0;
        rand_rdy  = 1'b0;
        rdy_fixed = 1'b1;
        repeat (3) @(posedge clk);
        #2 reset_n = 1'b1;

        // Basic decode and ordering
        send(4'd0, 32'h10);
        send(4'd1, 32'h20);
        send(4'd2, 32'h30);
        send(4'd3, 32'h40);
        drain();

        // Fill to full, hold a ninth record, release one pop
        rdy_fixed = 1'b0;
        for (int i = 0; i < DEPTH; i++) send(4'd0, 32'(32'h100 + i * 4));
        @(negedge clk);
        check("full_occupancy", 64'(occupancy), 64'd8);
        check("full_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk);
        #2;
        fork
            send(4'd1, 32'h999);
            begin
                repeat (3) @(posedge clk);
                #2 rdy_fixed = 1'b1;
                @(posedge clk);
                #2 rdy_fixed = 1'b0;
            end
        join
        @(negedge clk);
        check("refill_occupancy", 64'(occupancy), 64'd8);
        drain();

        // Consumed codes
        send(4'd9, 32'h0);
        send(4'd5, 32'h0);
        send(4'd15, 32'h1234);
        repeat (2) @(posedge clk);
        #2;

        // RESET command forces address to zero
        send(4'd8, 32'hDEAD);
        drain();

        // Counter saturation
        for (int i = 0; i < 17; i++) send(4'd0, $urandom);
        drain();
        @(negedge clk);
        check("rd_cnt_saturated", 64'(rd_cnt), STATS_EN ? 64'(CMAX) : 64'd0);
        @(posedge clk);
        #2;

        // Reset with commands queued
        rdy_fixed = 1'b0;
        for (int i = 0; i < 4; i++) send(4'(i), 32'(32'h500 + i));
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("async_cmd_valid", 64'(cmd_valid), 64'd0);
        check("async_occupancy", 64'(occupancy), 64'd0);
        check("async_in_ready", 64'(in_ready), 64'd1);
        repeat (2) @(posedge clk);
        #2 reset_n = 1'b1;
        rdy_fixed = 1'b1;

        // Randomized traffic with random backpressure
        rand_rdy = 1'b1;
        for (int i = 0; i < 300; i++) begin
            logic [3:0] c;
            c = ($urandom_range(0, 9) < 7) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
            send(c, $urandom);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #2;
            end
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
